dm_sync_param: RTL and testbench

Parametrised, synchronous-read data memory for the single-cycle/pipelined CPU data path, successor to the fixed 32-word data memory. It supports byte, halfword and word loads/stores in big-endian lane order, with zero/sign extension, a req/ready/ack handshake and alignment/range error reporting. Contents are cleared by a hardware sequencer after reset or on request. A combinational debug port exposes any word to the test harness.

---
 rtl/dm_sync_param.sv | 81 ++++++++
 tb/tb_dm_sync_param.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dm_sync_param.sv
// dm_sync_param: parametrised big-endian byte/half/word data memory with clear sequencer and req/ack handshake.
// Define DM_ALIGN_CHECK_EN to enable misalignment, illegal-size and range error detection.
module dm_sync_param #(
  parameter int ADDR_W     = 12,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [1:0]            i_size,
  input  logic                  i_sext,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [31:0]           i_din,
  input  logic                  i_clr,
  output logic                  o_ready,
  output logic                  o_ack,
  output logic                  o_err,
  output logic [31:0]           o_dout,
  input  logic [DEPTH_LOG2-1:0] i_test_addr,
  output logic [31:0]           o_test_data
);
`ifdef DM_ALIGN_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t                r_state;
  logic [DEPTH_LOG2-1:0] r_cnt;
  logic [31:0]           r_mem [2**DEPTH_LOG2];
  logic                  r_ack, r_err;
  logic [31:0]           r_dout;
  logic                  w_acc, w_bad;
  logic [1:0]            w_sz;
  logic [4:0]            w_sh;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [31:0]           w_rd, w_mask, w_wdata, w_lane, w_load;
  // size 11 behaves as a word; lane shift comes from the big-endian offset
  assign w_sz    = (i_size == 2'b11) ? 2'b10 : i_size;
  assign w_idx   = i_addr[DEPTH_LOG2+1:2];
  assign w_rd    = r_mem[w_idx];
  assign w_sh    = (w_sz == 2'b00) ? {~i_addr[1:0], 3'b000} : (w_sz == 2'b01) ? {~i_addr[1], 4'b0000} : 5'd0;
  assign w_mask  = ((w_sz == 2'b00) ? 32'h0000_00FF : (w_sz == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF) << w_sh;
  assign w_wdata = (i_din << w_sh) & w_mask;
  assign w_lane  = w_rd >> w_sh;
  assign w_load  = (w_sz == 2'b00) ? {{24{i_sext & w_lane[7]}}, w_lane[7:0]} :
                   (w_sz == 2'b01) ? {{16{i_sext & w_lane[15]}}, w_lane[15:0]} : w_lane;
  assign w_bad   = CHK & ((i_size == 2'b11) | ((i_size == 2'b01) & i_addr[0]) |
                   ((i_size == 2'b10) & (|i_addr[1:0])) | ((i_addr >> (DEPTH_LOG2 + 2)) != '0));
  assign w_acc   = i_req & (r_state == IDLE);
  assign o_ready = (r_state == IDLE);
  assign o_ack   = r_ack;
  assign o_err   = r_err;
  assign o_dout  = r_dout;
  assign o_test_data = r_mem[i_test_addr];
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_ack <= w_acc;
      r_err <= w_acc & w_bad;
      if (w_acc & ~i_we) r_dout <= w_bad ? '0 : w_load;
      if (r_state == CLEAR) begin
        r_cnt <= r_cnt + 1'b1;
        if (&r_cnt) r_state <= IDLE;
      end else if (i_clr) begin
        r_cnt   <= '0;
        r_state <= CLEAR;
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (r_state == CLEAR) r_mem[r_cnt] <= '0;
    else if (w_acc & i_we & ~w_bad) r_mem[w_idx] <= (w_rd & ~w_mask) | w_wdata;
  end
endmodule

// File: tb/tb_dm_sync_param.sv
// tb_dm_sync_param: scoreboard bench for dm_sync_param; expectations come from a bench-side memory model.
module tb_dm_sync_param;
`ifdef DM_ALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n, req, we, sext, clr;
  logic [1:0]  size;
  logic [11:0] addr;
  logic [31:0] din, dout, test_data;
  logic [4:0]  test_addr;
  logic        ready, ack, err;
  typedef struct packed {logic err; logic [31:0] dout;} exp_t;
  exp_t        q[$];
  logic [31:0] m_mem [32];
  logic [31:0] m_dout;
  int          total = 0;
  int          bad = 0;

  dm_sync_param dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_size(size), .i_sext(sext),
    .i_addr(addr), .i_din(din), .i_clr(clr), .o_ready(ready), .o_ack(ack), .o_err(err),
    .o_dout(dout), .i_test_addr(test_addr), .o_test_data(test_data)
  );

  always #5 clk = ~clk;

  task automatic zero_model();
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic sx, input logic [11:0] a,
                       input logic [31:0] d, input logic c, input string nm);
    exp_t        e;
    exp_t        g;
    logic [4:0]  ix;
    logic [31:0] wd;
    logic [7:0]  b;
    logic [15:0] h;
    @(negedge clk);
    req = 1'b1; we = w; size = sz; sext = sx; addr = a; din = d; clr = c;
    ix = a[6:2];
    wd = m_mem[ix];
    e.err = CHK && (sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) || a[11:7] != 5'd0);
    if (!w) begin
      if (sz == 2'b00) begin
        b = wd[8*(3-a[1:0]) +: 8];
        m_dout = {{24{sx & b[7]}}, b};
      end else if (sz == 2'b01) begin
        h = a[1] ? wd[15:0] : wd[31:16];
        m_dout = {{16{sx & h[15]}}, h};
      end else m_dout = wd;
      if (e.err) m_dout = '0;
    end else if (!e.err) begin
      if (sz == 2'b00) m_mem[ix][8*(3-a[1:0]) +: 8] = d[7:0];
      else if (sz == 2'b01) begin
        if (a[1]) m_mem[ix][15:0] = d[15:0];
        else m_mem[ix][31:16] = d[15:0];
      end else m_mem[ix] = d;
    end
    e.dout = m_dout;
    q.push_back(e);
    @(posedge clk); #1;
    req = 1'b0; clr = 1'b0;
    g = q.pop_front();
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL %s ack: got %b want 1", nm, ack); end
    total++; if (err !== g.err) begin bad++; $display("FAIL %s err: got %b want %b", nm, err, g.err); end
    total++; if (dout !== g.dout) begin bad++; $display("FAIL %s dout: got %h want %h", nm, dout, g.dout); end
  endtask

  task automatic idle_cycle(input string nm);
    @(posedge clk); #1;
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL %s idle ack: got %b want 0", nm, ack); end
    total++; if (dout !== m_dout) begin bad++; $display("FAIL %s held dout: got %h want %h", nm, dout, m_dout); end
  endtask

  task automatic wait_clear(input string nm);
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
      total++;
      if (ready !== (k == 32)) begin bad++; $display("FAIL %s ready edge %0d: got %b want %b", nm, k, ready, k == 32); end
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL %s clear ack edge %0d: got %b want 0", nm, k, ack); end
    end
    zero_model();
  endtask

  task automatic check_mem(input string nm);
    for (int i = 0; i < 32; i++) begin
      test_addr = 5'(i); #1;
      total++;
      if (test_data !== m_mem[i]) begin bad++; $display("FAIL %s word %0d: got %h want %h", nm, i, test_data, m_mem[i]); end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 0; we = 0; size = 0; sext = 0; addr = 0; din = 0; clr = 0; test_addr = 0;
    m_dout = '0;
    repeat (2) @(posedge clk); #1;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset ready: got %b want 0", ready); end
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL reset ack: got %b want 0", ack); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset err: got %b want 0", err); end
    total++; if (dout !== 32'h0) begin bad++; $display("FAIL reset dout: got %h want 0", dout); end
    @(negedge clk); rst_n = 1'b1;
    wait_clear("reset");
    check_mem("reset_mem");
  endtask

  task automatic test_word_byte();
    issue(1, 2'b10, 0, 12'h010, 32'h1122_3344, 0, "st_w");
    issue(0, 2'b00, 1, 12'h010, 32'h0, 0, "ld_b0");
    issue(0, 2'b00, 1, 12'h013, 32'h0, 0, "ld_b3");
    issue(0, 2'b01, 0, 12'h012, 32'h0, 0, "ld_h2");
    issue(0, 2'b01, 1, 12'h010, 32'h0, 0, "ld_h0");
    idle_cycle("word_byte");
  endtask

  task automatic test_byte_store();
    issue(1, 2'b10, 0, 12'h014, 32'hAABB_CCDD, 0, "st_w14");
    issue(1, 2'b00, 0, 12'h015, 32'hFFFF_FF80, 0, "st_b15");
    issue(0, 2'b10, 0, 12'h014, 32'h0, 0, "ld_w14");
    issue(0, 2'b00, 1, 12'h015, 32'h0, 0, "ld_b15s");
    issue(0, 2'b00, 0, 12'h015, 32'h0, 0, "ld_b15z");
    issue(1, 2'b01, 0, 12'h016, 32'h0000_8001, 0, "st_h16");
    issue(0, 2'b01, 1, 12'h016, 32'h0, 0, "ld_h16s");
    issue(1, 2'b00, 0, 12'h017, 32'h0000_0055, 0, "st_b17");
    issue(0, 2'b10, 0, 12'h014, 32'h0, 0, "ld_w14b");
    check_mem("byte_mem");
  endtask

  task automatic test_errors();
    issue(1, 2'b10, 0, 12'h006, 32'h5555_AAAA, 0, "st_mis");
    issue(1, 2'b10, 0, 12'h080, 32'h0BAD_0BAD, 0, "st_oor");
    issue(0, 2'b11, 0, 12'h010, 32'h0, 0, "ld_sz3");
    issue(0, 2'b01, 1, 12'h011, 32'h0, 0, "ld_hmis");
    issue(0, 2'b10, 0, 12'h094, 32'h0, 0, "ld_oor");
    issue(1, 2'b01, 0, 12'h00B, 32'h0000_1234, 0, "st_hmis");
    issue(0, 2'b10, 0, 12'h008, 32'h0, 0, "ld_w8");
    idle_cycle("errors");
    check_mem("err_mem");
  endtask

  task automatic test_back_to_back();
    issue(1, 2'b10, 0, 12'h020, 32'hDEAD_BEEF, 0, "b2b_st");
    issue(0, 2'b10, 0, 12'h020, 32'h0, 0, "b2b_ld");
    issue(1, 2'b00, 0, 12'h021, 32'h0000_0042, 0, "b2b_stb");
    issue(0, 2'b10, 0, 12'h020, 32'h0, 0, "b2b_ld2");
    idle_cycle("b2b");
  endtask

  task automatic test_clear();
    issue(1, 2'b10, 0, 12'h020, 32'h1234_5678, 1, "clr_st");
    test_addr = 5'd8; #1;
    total++; if (test_data !== 32'h1234_5678) begin bad++; $display("FAIL clr_commit: got %h want 12345678", test_data); end
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 12'h000; din = 32'hFFFF_FFFF;
    wait_clear("clear");
    req = 1'b0;
    check_mem("clear_mem");
    issue(0, 2'b10, 0, 12'h020, 32'h0, 0, "clr_ld");
  endtask

  task automatic test_rst_mid_clear();
    issue(1, 2'b10, 0, 12'h030, 32'hCAFE_F00D, 1, "mid_st");
    repeat (10) @(posedge clk);
    @(negedge clk); rst_n = 1'b0; #1;
    m_dout = '0;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL mid_rst ready: got %b want 0", ready); end
    total++; if (dout !== 32'h0) begin bad++; $display("FAIL mid_rst dout: got %h want 0", dout); end
    @(negedge clk); rst_n = 1'b1;
    wait_clear("mid_rst");
    check_mem("mid_mem");
    issue(1, 2'b10, 0, 12'h004, 32'h0F0F_0F0F, 0, "pre_st");
    issue(0, 2'b10, 0, 12'h004, 32'h0, 0, "pre_ld");
    #1 rst_n = 1'b0; #1;
    m_dout = '0;
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL drop_ack: got %b want 0", ack); end
    total++; if (dout !== 32'h0) begin bad++; $display("FAIL drop_dout: got %h want 0", dout); end
    @(negedge clk); rst_n = 1'b1;
    wait_clear("drop");
    check_mem("drop_mem");
  endtask

  initial begin
    test_reset();
    test_word_byte();
    test_byte_store();
    test_errors();
    test_back_to_back();
    test_clear();
    test_rst_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
